// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: opcodes, one-hot T-state encodings and
// control-word bit positions used by the sequencer and the datapath top level.
package sap1_pkg;

    // Instruction opcodes (upper nibble of the instruction register)
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // One-hot ring counter states
    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    // Control-word bit positions
    localparam int CW_WIDTH    = 12;
    localparam int CW_PC_INC   = 0;
    localparam int CW_PC_EO    = 1;
    localparam int CW_MAR_EI   = 2;
    localparam int CW_RAM_EO   = 3;
    localparam int CW_IR_EI    = 4;
    localparam int CW_IR_EO    = 5;
    localparam int CW_A_EI     = 6;
    localparam int CW_A_EO     = 7;
    localparam int CW_B_EI     = 8;
    localparam int CW_ALU_SUB  = 9;
    localparam int CW_ALU_EO   = 10;
    localparam int CW_OUT_EI   = 11;

    // True when exactly one bit of a 6-bit vector is set
    function automatic logic one_hot6(input logic [5:0] v);
        return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
    endfunction

endpackage

// File: rtl/ring_counter_6.sv
// Six-state one-hot ring counter: rotates left while run is high and freeze
// is low, holds otherwise; clear_n low forces T1 on the next rising edge.
module ring_counter_6
    import sap1_pkg::*;
(
    input  logic       clk,
    input  logic       clear_n,
    input  logic       run,
    input  logic       freeze,
    output logic [5:0] t_state
);

    logic [5:0] t_state_d;
    logic [5:0] t_state_q;

    // Next T-state: rotate, hold, or recover to T1 from a corrupted encoding
    always_comb begin
        t_state_d = t_state_q;
        if (!one_hot6(t_state_q)) begin
            t_state_d = T1;
        end else if (run && !freeze) begin
            t_state_d = {t_state_q[4:0], t_state_q[5]};
        end else begin
            t_state_d = t_state_q;
        end
    end

    // T-state register with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            t_state_q <= T1;
        end else begin
            t_state_q <= t_state_d;
        end
    end

    assign t_state = t_state_q;

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 control unit: ring-counter sequencing plus Moore decode of
// (T-state, opcode, halted) into the datapath load/enable strobes.
// This block owns every bus-driver enable, so bus arbitration lives here.
module controller_sequencer
    import sap1_pkg::*;
(
    input  logic       Clock,
    input  logic       Clear,
    input  logic       run,
    input  logic [3:0] opcode,
    output logic [5:0] t_state,
    output logic       halted,
    output logic       pc_increment,
    output logic       pc_enable_output,
    output logic       mar_enable_input,
    output logic       ram_enable_output,
    output logic       ir_enable_input,
    output logic       ir_enable_output,
    output logic       a_enable_input,
    output logic       a_enable_output,
    output logic       b_enable_input,
    output logic       alu_subtract,
    output logic       alu_enable_output,
    output logic       out_enable_input
);

    logic [5:0]          t_state_s;
    logic                halted_d;
    logic                halted_q;
    logic                hlt_at_t4_s;
    logic                freeze_s;
    logic [CW_WIDTH-1:0] cw_s;

    // HLT seen in T4 stops the ring at T4; once halted only Clear restarts it
    assign hlt_at_t4_s = (t_state_s == T4) && (opcode == OP_HLT);
    assign freeze_s    = halted_q || hlt_at_t4_s;

    ring_counter_6 u_ring (
        .clk     (Clock),
        .clear_n (Clear),
        .run     (run),
        .freeze  (freeze_s),
        .t_state (t_state_s)
    );

    // Halt flag becomes sticky at the end of an HLT T4 when the sequence is running
    always_comb begin
        halted_d = halted_q;
        if (halted_q) begin
            halted_d = 1'b1;
        end else if (run && hlt_at_t4_s) begin
            halted_d = 1'b1;
        end else begin
            halted_d = 1'b0;
        end
    end

    // Halt register with synchronous active-low clear
    always_ff @(posedge Clock) begin
        if (!Clear) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    // Control-word decode; opcode is only looked at from T4 onwards
    always_comb begin
        cw_s = '0;
        if (halted_q) begin
            cw_s = '0;
        end else begin
            case (t_state_s)
                T1: begin
                    cw_s[CW_PC_EO]  = 1'b1;
                    cw_s[CW_MAR_EI] = 1'b1;
                end
                T2: begin
                    cw_s[CW_PC_INC] = 1'b1;
                end
                T3: begin
                    cw_s[CW_RAM_EO] = 1'b1;
                    cw_s[CW_IR_EI]  = 1'b1;
                end
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            cw_s[CW_IR_EO]  = 1'b1;
                            cw_s[CW_MAR_EI] = 1'b1;
                        end
                        OP_OUT: begin
                            cw_s[CW_A_EO]   = 1'b1;
                            cw_s[CW_OUT_EI] = 1'b1;
                        end
                        default: cw_s = '0;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA: begin
                            cw_s[CW_RAM_EO] = 1'b1;
                            cw_s[CW_A_EI]   = 1'b1;
                        end
                        OP_ADD: begin
                            cw_s[CW_RAM_EO] = 1'b1;
                            cw_s[CW_B_EI]   = 1'b1;
                        end
                        OP_SUB: begin
                            cw_s[CW_RAM_EO]  = 1'b1;
                            cw_s[CW_B_EI]    = 1'b1;
                            cw_s[CW_ALU_SUB] = 1'b1;
                        end
                        default: cw_s = '0;
                    endcase
                end
                T6: begin
                    case (opcode)
                        OP_ADD: begin
                            cw_s[CW_ALU_EO] = 1'b1;
                            cw_s[CW_A_EI]   = 1'b1;
                        end
                        OP_SUB: begin
                            cw_s[CW_ALU_EO]  = 1'b1;
                            cw_s[CW_A_EI]    = 1'b1;
                            cw_s[CW_ALU_SUB] = 1'b1;
                        end
                        default: cw_s = '0;
                    endcase
                end
                default: cw_s = '0;
            endcase
        end
    end

    assign t_state           = t_state_s;
    assign halted            = halted_q;
    assign pc_increment      = cw_s[CW_PC_INC];
    assign pc_enable_output  = cw_s[CW_PC_EO];
    assign mar_enable_input  = cw_s[CW_MAR_EI];
    assign ram_enable_output = cw_s[CW_RAM_EO];
    assign ir_enable_input   = cw_s[CW_IR_EI];
    assign ir_enable_output  = cw_s[CW_IR_EO];
    assign a_enable_input    = cw_s[CW_A_EI];
    assign a_enable_output   = cw_s[CW_A_EO];
    assign b_enable_input    = cw_s[CW_B_EI];
    assign alu_subtract      = cw_s[CW_ALU_SUB];
    assign alu_enable_output = cw_s[CW_ALU_EO];
    assign out_enable_input  = cw_s[CW_OUT_EI];

endmodule

// File: tb/tb_controller_sequencer.sv
// Self-checking bench for the SAP-1 controller/sequencer: a vector table for
// the per-opcode microcode, hand-written multi-cycle corner cases, and a
// randomized run against a phase/halt reference model.
module tb_controller_sequencer;

    logic       clk = 1'b0;
    logic       Clear;
    logic       run;
    logic [3:0] opcode;
    logic [5:0] t_state;
    logic       halted;
    logic       pc_increment, pc_enable_output, mar_enable_input, ram_enable_output;
    logic       ir_enable_input, ir_enable_output, a_enable_input, a_enable_output;
    logic       b_enable_input, alu_subtract, alu_enable_output, out_enable_input;

    controller_sequencer dut (
        .Clock             (clk),
        .Clear             (Clear),
        .run               (run),
        .opcode            (opcode),
        .t_state           (t_state),
        .halted            (halted),
        .pc_increment      (pc_increment),
        .pc_enable_output  (pc_enable_output),
        .mar_enable_input  (mar_enable_input),
        .ram_enable_output (ram_enable_output),
        .ir_enable_input   (ir_enable_input),
        .ir_enable_output  (ir_enable_output),
        .a_enable_input    (a_enable_input),
        .a_enable_output   (a_enable_output),
        .b_enable_input    (b_enable_input),
        .alu_subtract      (alu_subtract),
        .alu_enable_output (alu_enable_output),
        .out_enable_input  (out_enable_input)
    );

    always #5 clk = ~clk;

    // Bench-side strobe word layout
    localparam logic [11:0] S_NONE = 12'h000;
    localparam logic [11:0] S_PCI  = 12'h800;
    localparam logic [11:0] S_PCO  = 12'h400;
    localparam logic [11:0] S_MARI = 12'h200;
    localparam logic [11:0] S_RAMO = 12'h100;
    localparam logic [11:0] S_IRI  = 12'h080;
    localparam logic [11:0] S_IRO  = 12'h040;
    localparam logic [11:0] S_AI   = 12'h020;
    localparam logic [11:0] S_AO   = 12'h010;
    localparam logic [11:0] S_BI   = 12'h008;
    localparam logic [11:0] S_SUB  = 12'h004;
    localparam logic [11:0] S_ALUO = 12'h002;
    localparam logic [11:0] S_OUTI = 12'h001;

    wire [11:0] strobes = {pc_increment, pc_enable_output, mar_enable_input, ram_enable_output,
                           ir_enable_input, ir_enable_output, a_enable_input, a_enable_output,
                           b_enable_input, alu_subtract, alu_enable_output, out_enable_input};

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        clear_n;
        logic        run;
        logic [3:0]  op;
        logic [5:0]  ts;
        logic        halt;
        logic [11:0] st;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: position within the instruction and halt flag
    int m_phase;
    bit m_halt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare outputs with expectations, then check the bus invariants
    task automatic check(input string name, input logic [5:0] ts, input logic h,
                         input logic [11:0] st);
        int drivers;
        int loads;
        #1;
        n_checks++;
        if (t_state !== ts || halted !== h || strobes !== st) begin
            n_fail++;
            $display("FAIL %s: got t_state=%b halted=%b strobes=%h, expected t_state=%b halted=%b strobes=%h",
                     name, t_state, halted, strobes, ts, h, st);
        end
        drivers = int'(pc_enable_output) + int'(ram_enable_output) + int'(ir_enable_output)
                + int'(a_enable_output) + int'(alu_enable_output);
        loads   = int'(mar_enable_input) + int'(ir_enable_input) + int'(a_enable_input)
                + int'(b_enable_input) + int'(out_enable_input);
        n_checks++;
        if (drivers > 1 || (loads > 0 && drivers == 0)) begin
            n_fail++;
            $display("FAIL bus_%s: drivers=%0d loads=%0d, expected drivers<=1 and no load without a driver",
                     name, drivers, loads);
        end
    endtask

    task automatic add_vec(input logic [3:0] op, input logic [5:0] ts, input logic [11:0] st);
        vec_t v;
        v.clear_n = 1'b1;
        v.run     = 1'b1;
        v.op      = op;
        v.ts      = ts;
        v.halt    = 1'b0;
        v.st      = st;
        vecs.push_back(v);
    endtask

    // One instruction: fetch with a misleading HLT opcode (must be ignored), then execute
    task automatic add_instr(input logic [3:0] op, input logic [11:0] w4,
                             input logic [11:0] w5, input logic [11:0] w6);
        add_vec(4'hF, 6'b000001, S_PCO | S_MARI);
        add_vec(4'hF, 6'b000010, S_PCI);
        add_vec(4'hF, 6'b000100, S_RAMO | S_IRI);
        add_vec(op,   6'b001000, w4);
        add_vec(op,   6'b010000, w5);
        add_vec(op,   6'b100000, w6);
    endtask

    // Expected strobes from the instruction's microprogram
    function automatic logic [11:0] model_word(input int phase, input logic [3:0] op, input bit h);
        logic [11:0] ex [3];
        if (h) return S_NONE;
        if (phase == 0) return S_PCO | S_MARI;
        if (phase == 1) return S_PCI;
        if (phase == 2) return S_RAMO | S_IRI;
        case (op)
            4'h0:    ex = '{S_IRO | S_MARI, S_RAMO | S_AI, S_NONE};
            4'h1:    ex = '{S_IRO | S_MARI, S_RAMO | S_BI, S_ALUO | S_AI};
            4'h2:    ex = '{S_IRO | S_MARI, S_RAMO | S_BI | S_SUB, S_ALUO | S_AI | S_SUB};
            4'hE:    ex = '{S_AO | S_OUTI, S_NONE, S_NONE};
            default: ex = '{S_NONE, S_NONE, S_NONE};
        endcase
        return ex[phase - 3];
    endfunction

    // Advance the model by one rising edge with the given inputs
    task automatic model_step(input logic c, input logic r, input logic [3:0] op);
        if (!c) begin
            m_phase = 0;
            m_halt  = 1'b0;
        end else if (r && !m_halt) begin
            if (m_phase == 3 && op == 4'hF) m_halt = 1'b1;
            else m_phase = (m_phase + 1) % 6;
        end
    endtask

    initial begin
        logic [5:0] exp_ts;

        // Reset
        Clear  = 1'b0;
        run    = 1'b1;
        opcode = 4'h0;
        tick();
        tick();

        // Microcode table
        add_instr(4'h1, S_IRO | S_MARI, S_RAMO | S_BI,         S_ALUO | S_AI);
        add_instr(4'h2, S_IRO | S_MARI, S_RAMO | S_BI | S_SUB, S_ALUO | S_AI | S_SUB);
        add_instr(4'hE, S_AO | S_OUTI,  S_NONE,                S_NONE);
        add_instr(4'h0, S_IRO | S_MARI, S_RAMO | S_AI,         S_NONE);
        add_instr(4'h7, S_NONE,         S_NONE,                S_NONE);
        for (int i = 0; i < vecs.size(); i++) begin
            Clear  = vecs[i].clear_n;
            run    = vecs[i].run;
            opcode = vecs[i].op;
            check($sformatf("vec%0d", i), vecs[i].ts, vecs[i].halt, vecs[i].st);
            tick();
        end

        // HLT: freezes at T4 with all strobes low until Clear
        opcode = 4'hF;
        check("hlt_t1", 6'b000001, 1'b0, S_PCO | S_MARI);
        tick();
        check("hlt_t2", 6'b000010, 1'b0, S_PCI);
        tick();
        check("hlt_t3", 6'b000100, 1'b0, S_RAMO | S_IRI);
        tick();
        check("hlt_t4", 6'b001000, 1'b0, S_NONE);
        tick();
        for (int i = 0; i < 22; i++) begin
            run    = 1'($urandom_range(0, 1));
            opcode = 4'($urandom_range(0, 15));
            check($sformatf("halted%0d", i), 6'b001000, 1'b1, S_NONE);
            tick();
        end
        Clear = 1'b0;
        run   = 1'b1;
        tick();
        Clear = 1'b1;
        check("hlt_clear", 6'b000001, 1'b0, S_PCO | S_MARI);

        // run dropped in T3 for five cycles, then NOP execute
        opcode = 4'h7;
        tick();
        tick();
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold_t3_%0d", i), 6'b000100, 1'b0, S_RAMO | S_IRI);
            tick();
        end
        run = 1'b1;
        check("resume_t3", 6'b000100, 1'b0, S_RAMO | S_IRI);
        tick();
        check("nop_t4", 6'b001000, 1'b0, S_NONE);
        tick();
        check("nop_t5", 6'b010000, 1'b0, S_NONE);
        tick();
        check("nop_t6", 6'b100000, 1'b0, S_NONE);
        tick();
        check("nop_wrap", 6'b000001, 1'b0, S_PCO | S_MARI);

        // Clear during T5 of ADD abandons the instruction
        opcode = 4'h1;
        tick();
        tick();
        tick();
        tick();
        check("add_t5", 6'b010000, 1'b0, S_RAMO | S_BI);
        Clear = 1'b0;
        tick();
        Clear = 1'b1;
        check("clr_mid_t1", 6'b000001, 1'b0, S_PCO | S_MARI);
        tick();
        check("clr_mid_t2", 6'b000010, 1'b0, S_PCI);

        // Randomized run against the reference model
        Clear = 1'b0;
        tick();
        m_phase = 0;
        m_halt  = 1'b0;
        for (int i = 0; i < 800; i++) begin
            Clear  = ($urandom_range(0, 99) >= 3);
            run    = ($urandom_range(0, 99) < 80);
            opcode = 4'($urandom_range(0, 15));
            exp_ts = 6'(1 << m_phase);
            check($sformatf("rand%0d", i), exp_ts, m_halt, model_word(m_phase, opcode, m_halt));
            tick();
            model_step(Clear, run, opcode);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/controller_sequencer.md
Name: controller_sequencer

Overview:
- Control unit of the SAP-1 machine.
- A six-state ring counter (T1..T6) sequences the fetch and execute phases.
- The 4-bit opcode from the instruction register is decoded into active-high load/enable/increment strobes for the PC, MAR, RAM, IR, A, B, ALU and output register.
- It owns all bus-driver enables, so it is the sole arbiter of the shared 8-bit data bus.

Parameters:
- OP_LDA, 4'h0, load-accumulator opcode
- OP_ADD, 4'h1, add opcode
- OP_SUB, 4'h2, subtract opcode
- OP_OUT, 4'hE, output opcode
- OP_HLT, 4'hF, halt opcode

Ports:
- Clock  input  1  system clock; all state changes on its rising edge
- Clear  input  1  reset, synchronous, active-low
- run  input  1  1 = sequence advances; 0 = ring counter holds its current T-state
- opcode  input  4  instruction-register upper nibble
- t_state  output  6  one-hot current T-state; bit0 = T1 … bit5 = T6
- halted  output  1  high after HLT is executed
- pc_increment  output  1  program counter increments at next edge
- pc_enable_output  output  1  PC drives bus
- mar_enable_input  output  1  MAR loads from bus
- ram_enable_output  output  1  RAM drives bus
- ir_enable_input  output  1  IR loads from bus
- ir_enable_output  output  1  IR drives operand nibble onto bus
- a_enable_input  output  1  accumulator loads
- a_enable_output  output  1  accumulator drives bus
- b_enable_input  output  1  B register loads
- alu_subtract  output  1  ALU performs A-B, else A+B
- alu_enable_output  output  1  ALU drives bus
- out_enable_input  output  1  output register loads

Behaviour:
- Clock and reset: one clock (Clock). Reset (Clear) is synchronous and active-low. Clear low at a rising edge forces t_state = 6'b000001 (T1) and halted = 0. This overrides run, HLT and any in-progress instruction, so reset mid-instruction abandons it cleanly.
- Decode style: Moore.
  - Every strobe is a combinational decode of the registered t_state, opcode and halted.
  - A strobe is valid for the whole T-state; the datapath captures on the rising edge that ends that T-state.
  - Outputs out of reset equal the T1 word: pc_enable_output = 1, mar_enable_input = 1, all others 0.
- Advance: when run = 1 and not halted, t_state rotates left each edge (T6 -> T1). When run = 0, t_state and halted hold, and strobes remain those of the held state.
- Fetch, opcode-independent:
  - T1: pc_enable_output, mar_enable_input.
  - T2: pc_increment.
  - T3: ram_enable_output, ir_enable_input.
  - opcode is treated as valid only from T4; its value in T1..T3 is ignored.
- Execute:
  - LDA: T4 ir_enable_output + mar_enable_input; T5 ram_enable_output + a_enable_input; T6 none.
  - ADD: T4 as LDA; T5 ram_enable_output + b_enable_input; T6 alu_enable_output + a_enable_input.
  - SUB: as ADD, with alu_subtract high in T5 and T6.
  - OUT: T4 a_enable_output + out_enable_input; T5, T6 none.
  - HLT:
    - T4 asserts no strobes; at the end of T4 (when run = 1), halted goes to 1 and t_state freezes at T4.
    - While halted, all strobes are 0 regardless of opcode or run.
    - Only Clear exits the halted state.
  - Any other opcode: NOP; T4..T6 assert no strobes, and the sequence continues normally.
- Invariants:
  - t_state is always exactly one-hot.
  - At most one of pc_enable_output, ram_enable_output, ir_enable_output, a_enable_output, alu_enable_output is high in any cycle (no bus contention).
  - A register never loads from the bus in a cycle where no driver is enabled.
- Latency: each instruction takes 6 cycles with run held high; HLT halts 4 cycles after its T1.

Decomposition:
- Shared package sap1_pkg:
  - opcode constants (the parameters above)
  - T-state one-hot encodings T1..T6
  - control-word bit index constants, shared by the datapath top level
- One natural sub-module, ring_counter_6: one-hot rotate with run hold, Clear to T1, and a freeze input driven by the halt logic. All decode logic stays in controller_sequencer.

Test Plan:
- Clear low one edge, then high with run = 1 -> t_state 000001, pc_enable_output = 1 and mar_enable_input = 1 in that cycle; t_state 000010 with only pc_increment on the next cycle.
- opcode = 4'h1 (ADD) over one full cycle -> T5 asserts ram_enable_output + b_enable_input; T6 asserts alu_enable_output + a_enable_input with alu_subtract = 0; t_state then returns to 000001.
- opcode = 4'h2 (SUB) -> identical to ADD except alu_subtract = 1 in T5 and T6. opcode = 4'hE (OUT) -> T4 asserts a_enable_output + out_enable_input only.
- opcode = 4'hF (HLT) -> halted = 1 after the T4 edge; t_state stays 001000 and all strobes stay 0 for 20+ cycles. Clear low then -> T1, halted = 0.
- run dropped in T3 for 5 cycles -> t_state stays 000100 with ram_enable_output + ir_enable_input held; advances to T4 on the first edge after run returns high. Opcode 4'h7 -> no strobes in T4..T6.
- Clear low during T5 of ADD -> next cycle T1; b_enable_input not asserted after that edge. A bus-contention assertion runs in all tests.
